// File: rtl/i2c_master_byte_engine_if.sv
// Command, byte-stream and open-drain line signals of the I2C byte engine.
// master = the engine itself, slave = the environment driving it.
interface i2c_master_byte_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_read_write;
  logic       cmd_msb_first;
  logic [7:0] cmd_num_bytes;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       scl_o;
  logic       sda_o;
  logic       sda_i;
  logic       busy;
  logic       done;
  logic       nack;

  modport master (
    input  cmd_valid, cmd_addr, cmd_read_write, cmd_msb_first, cmd_num_bytes,
           wr_data, wr_valid, sda_i,
    output cmd_ready, wr_ready, rd_data, rd_valid, scl_o, sda_o, busy, done, nack
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_read_write, cmd_msb_first, cmd_num_bytes,
           wr_data, wr_valid, sda_i,
    input  cmd_ready, wr_ready, rd_data, rd_valid, scl_o, sda_o, busy, done, nack
  );
endinterface

// File: rtl/i2c_master_byte_engine.sv
// I2C master bit/byte engine: START, address, write/read bytes with ACK handling, STOP.
// SCL/SDA are decoded from registered state so an async reset releases the lines at once.
module i2c_master_byte_engine #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned DATA_LENGTH = 8,
  parameter int unsigned NO_OF_ROWS  = 128
) (
  input logic                      pclk,
  input logic                      areset,
  i2c_master_byte_engine_if.master bus
);
  localparam int unsigned   QW        = $clog2(CLK_DIV);
  localparam logic [QW-1:0] Q_LAST    = QW'(CLK_DIV - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_LENGTH - 1);
  localparam logic [7:0]    MAX_BYTES = 8'(NO_OF_ROWS);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP
  } state_t;

  state_t        state, state_nxt;
  logic [QW-1:0] qcnt, qcnt_nxt;
  logic [1:0]    quarter, quarter_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    byte_cnt, byte_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [6:0]    addr, addr_nxt;
  logic          rw, rw_nxt;
  logic          msb, msb_nxt;
  logic          have_byte, have_byte_nxt;
  logic          ack_bit, ack_bit_nxt;
  logic          nack, nack_nxt;
  logic [7:0]    rd_data, rd_data_nxt;
  logic          rd_valid, rd_valid_nxt;
  logic          wr_ready, wr_ready_nxt;
  logic          done, done_nxt;
  logic          scl, sda;
  logic          tick, sample, slot_end, stall, tx_bit;
  logic [7:0]    tx_shift, rx_shift;

  assign tick     = (qcnt == Q_LAST);
  assign sample   = tick && (quarter == 2'd2);
  assign slot_end = tick && (quarter == 2'd3);
  // Clock stretching: the bit timer freezes at Q0 of bit 0 until a write byte arrives.
  assign stall    = (state == WR_DATA) && !have_byte && !bus.wr_valid;
  assign tx_bit   = msb ? shreg[7] : shreg[0];
  assign tx_shift = msb ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
  assign rx_shift = msb ? {shreg[6:0], bus.sda_i} : {bus.sda_i, shreg[7:1]};

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      qcnt      <= '0;
      quarter   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      addr      <= '0;
      rw        <= 1'b0;
      msb       <= 1'b0;
      have_byte <= 1'b0;
      ack_bit   <= 1'b0;
      nack      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      wr_ready  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      qcnt      <= qcnt_nxt;
      quarter   <= quarter_nxt;
      bit_cnt   <= bit_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      shreg     <= shreg_nxt;
      addr      <= addr_nxt;
      rw        <= rw_nxt;
      msb       <= msb_nxt;
      have_byte <= have_byte_nxt;
      ack_bit   <= ack_bit_nxt;
      nack      <= nack_nxt;
      rd_data   <= rd_data_nxt;
      rd_valid  <= rd_valid_nxt;
      wr_ready  <= wr_ready_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    qcnt_nxt      = qcnt;
    quarter_nxt   = quarter;
    bit_cnt_nxt   = bit_cnt;
    byte_cnt_nxt  = byte_cnt;
    shreg_nxt     = shreg;
    addr_nxt      = addr;
    rw_nxt        = rw;
    msb_nxt       = msb;
    have_byte_nxt = have_byte;
    ack_bit_nxt   = ack_bit;
    nack_nxt      = nack;
    rd_data_nxt   = rd_data;
    rd_valid_nxt  = 1'b0;
    wr_ready_nxt  = 1'b0;
    done_nxt      = 1'b0;

    if (state != IDLE && !stall) begin
      if (tick) begin
        qcnt_nxt    = '0;
        quarter_nxt = quarter + 2'd1;
      end else begin
        qcnt_nxt = qcnt + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_nxt    = START;
          addr_nxt     = bus.cmd_addr;
          rw_nxt       = bus.cmd_read_write;
          msb_nxt      = bus.cmd_msb_first;
          byte_cnt_nxt = (bus.cmd_num_bytes > MAX_BYTES) ? MAX_BYTES : bus.cmd_num_bytes;
          nack_nxt     = 1'b0;
        end
      end
      START: begin
        if (slot_end) begin
          state_nxt   = ADDR;
          shreg_nxt   = {addr, rw};
          bit_cnt_nxt = '0;
        end
      end
      ADDR: begin
        if (slot_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_nxt = ADDR_ACK;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shreg_nxt   = {shreg[6:0], 1'b0};
          end
        end
      end
      ADDR_ACK: begin
        if (sample) ack_bit_nxt = bus.sda_i;
        if (slot_end) begin
          bit_cnt_nxt = '0;
          if (ack_bit) begin
            nack_nxt  = 1'b1;
            state_nxt = STOP;
          end else if (byte_cnt == '0) begin
            state_nxt = STOP;
          end else begin
            state_nxt = rw ? RD_DATA : WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (!have_byte && bus.wr_valid) begin
          shreg_nxt     = bus.wr_data;
          have_byte_nxt = 1'b1;
          wr_ready_nxt  = 1'b1;
        end
        if (slot_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_nxt     = WR_ACK;
            have_byte_nxt = 1'b0;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shreg_nxt   = tx_shift;
          end
        end
      end
      WR_ACK: begin
        if (sample) ack_bit_nxt = bus.sda_i;
        if (slot_end) begin
          bit_cnt_nxt  = '0;
          byte_cnt_nxt = byte_cnt - 8'd1;
          if (ack_bit) begin
            nack_nxt  = 1'b1;
            state_nxt = STOP;
          end else begin
            state_nxt = (byte_cnt == 8'd1) ? STOP : WR_DATA;
          end
        end
      end
      RD_DATA: begin
        if (sample) shreg_nxt = rx_shift;
        if (slot_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_nxt    = RD_ACK;
            rd_data_nxt  = shreg;
            rd_valid_nxt = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      RD_ACK: begin
        if (slot_end) begin
          bit_cnt_nxt  = '0;
          byte_cnt_nxt = byte_cnt - 8'd1;
          state_nxt    = (byte_cnt == 8'd1) ? STOP : RD_DATA;
        end
      end
      STOP: begin
        if (slot_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    scl = 1'b1;
    sda = 1'b1;
    case (state)
      START:            sda = ~quarter[1];
      ADDR: begin
        scl = quarter[1];
        sda = shreg[7];
      end
      WR_DATA: begin
        scl = quarter[1];
        sda = have_byte ? tx_bit : 1'b1;
      end
      ADDR_ACK, WR_ACK, RD_DATA: scl = quarter[1];
      // Master ACKs every read byte except the last, which it NACKs.
      RD_ACK: begin
        scl = quarter[1];
        sda = (byte_cnt == 8'd1);
      end
      STOP: begin
        scl = (quarter != 2'd0);
        sda = quarter[1];
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.scl_o     = scl;
  assign bus.sda_o     = sda;
  assign bus.wr_ready  = wr_ready;
  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;
  assign bus.done      = done;
  assign bus.nack      = nack;
endmodule

// File: tb/tb_i2c_master_byte_engine.sv
// Scoreboard bench: a transaction-level model predicts line events, read bytes and
// completion status; independent monitors decode SCL/SDA and DUT outputs and compare.
module tb_i2c_master_byte_engine;
  localparam int unsigned CLK_DIV = 4;

  logic pclk;
  logic areset;
  logic slave_sda;
  i2c_master_byte_engine_if bus();

  assign bus.sda_i = bus.sda_o & slave_sda;

  i2c_master_byte_engine #(.CLK_DIV(CLK_DIV), .DATA_LENGTH(8), .NO_OF_ROWS(128)) dut (
    .pclk  (pclk),
    .areset(areset),
    .bus   (bus.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  longint cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct { logic nk; int wr; } done_t;
  int         exp_bus[$];     // 0/1 = bit seen on SCL rise, 2 = START, 3 = STOP
  logic [7:0] exp_rd[$];
  done_t      exp_done[$];
  logic [7:0] wq[$];
  logic [7:0] pat[128];
  logic [7:0] rbytes[128];
  logic       wack[128];
  logic       cfg_rw, cfg_msb, cfg_anack, hold, mon_en;
  int         cfg_n;
  int         done_cnt = 0, wr_seen = 0, start_cnt = 0, rise_idx = 0;

  task automatic check(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  function automatic logic slave_bit(input int fr, input int bn);
    if (bn == 8) begin
      if (fr == 0) return cfg_anack;
      if (!cfg_rw && fr <= cfg_n) return wack[fr-1];
      return 1'b1;
    end
    if (cfg_rw && !cfg_anack && fr >= 1 && fr <= cfg_n)
      return cfg_msb ? rbytes[fr-1][7-bn] : rbytes[fr-1][bn];
    return 1'b1;
  endfunction

  task automatic bus_event(input int ev);
    int e;
    if (!mon_en) return;
    if (exp_bus.size() == 0) begin
      total++; bad++;
      $display("FAIL bus_event_extra: got %0d required none", ev);
    end else begin
      e = exp_bus.pop_front();
      check("bus_event", ev, e);
    end
  endtask

  // Line monitor plus slave responder (ACKs, read data), sampled mid-cycle.
  initial begin
    logic ps, pd, s, d;
    int frame, bitn;
    longint t0;
    logic in_xfer;
    ps = 1'b1; pd = 1'b1; frame = 0; bitn = -1; t0 = 0; in_xfer = 1'b0;
    slave_sda = 1'b1;
    forever begin
      @(negedge pclk);
      s = bus.scl_o;
      d = bus.sda_i;
      if (areset) begin
        in_xfer = 1'b0;
        slave_sda = 1'b1;
      end else if (ps && s && pd && !d) begin
        in_xfer = 1'b1; frame = 0; bitn = -1; rise_idx = 0; start_cnt++;
        bus_event(2);
      end else if (ps && s && !pd && d) begin
        in_xfer = 1'b0; slave_sda = 1'b1;
        bus_event(3);
      end else if (!ps && s) begin
        bus_event(int'(d));
        if (rise_idx == 0) t0 = cyc;
        else if (rise_idx == 1 && mon_en) check("bit_time", cyc - t0, 4 * CLK_DIV);
        rise_idx++;
      end else if (ps && !s && in_xfer) begin
        bitn++;
        if (bitn == 9) begin bitn = 0; frame++; end
        slave_sda = slave_bit(frame, bitn);
      end
      ps = s; pd = d;
    end
  end

  // Output monitor: read bytes, write-byte consumption and completion status.
  initial begin
    done_t dn;
    forever begin
      @(negedge pclk);
      if (areset) wr_seen = 0;
      if (bus.wr_ready) wr_seen++;
      if (bus.rd_valid && mon_en) begin
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_extra: got 0x%0h required none", bus.rd_data);
        end else check("rd_data", bus.rd_data, exp_rd.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        if (mon_en) begin
          if (exp_done.size() == 0) begin
            total++; bad++;
            $display("FAIL done_extra: got nack=%0d required none", bus.nack);
          end else begin
            dn = exp_done.pop_front();
            check("done_nack", bus.nack, dn.nk);
            check("wr_ready_count", wr_seen, dn.wr);
          end
        end
        wr_seen = 0;
      end
    end
  end

  // Write-byte source: presents the head of wq, drops it when consumed.
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    forever begin
      @(posedge pclk);
      #1;
      if (bus.wr_ready && wq.size() > 0) void'(wq.pop_front());
      bus.wr_valid = (wq.size() > 0) && !hold;
      bus.wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  task automatic fill_pat();
    for (int i = 0; i < 128; i++) pat[i] = 8'($urandom);
  endtask

  task automatic issue(input logic [6:0] a, input logic rw, input logic msb, input int num);
    bus.cmd_addr       = a;
    bus.cmd_read_write = rw;
    bus.cmd_msb_first  = msb;
    bus.cmd_num_bytes  = 8'(num);
    bus.cmd_valid      = 1'b1;
    @(negedge pclk);
    bus.cmd_addr       = 7'($urandom);
    bus.cmd_read_write = 1'($urandom);
    bus.cmd_msb_first  = 1'($urandom);
    bus.cmd_num_bytes  = 8'($urandom);
  endtask

  task automatic run_xfer(input logic [6:0] a, input logic rw, input logic msb, input int num,
                          input logic anack, input int nack_at, input bit stall);
    int n, d0, wrexp, hi;
    logic nk;
    logic [7:0] ab;
    n = (num > 128) ? 128 : num;
    cfg_rw = rw; cfg_msb = msb; cfg_anack = anack; cfg_n = n;
    for (int i = 0; i < 128; i++) begin
      wack[i]   = (i == nack_at);
      rbytes[i] = pat[i];
    end
    wq.delete();
    if (!rw) for (int i = 0; i < n; i++) wq.push_back(pat[i]);

    ab = {a, rw};
    exp_bus.push_back(2);
    for (int b = 0; b < 8; b++) exp_bus.push_back(int'(ab[7-b]));
    exp_bus.push_back(int'(anack));
    nk = anack; wrexp = 0;
    if (!anack) begin
      for (int i = 0; i < n; i++) begin
        for (int b = 0; b < 8; b++) exp_bus.push_back(int'(msb ? pat[i][7-b] : pat[i][b]));
        if (rw) begin
          exp_bus.push_back((i == n - 1) ? 1 : 0);
          exp_rd.push_back(pat[i]);
        end else begin
          wrexp++;
          exp_bus.push_back((i == nack_at) ? 1 : 0);
          if (i == nack_at) begin nk = 1'b1; break; end
        end
      end
    end
    exp_bus.push_back(0);   // STOP clocks SCL high once with SDA low before releasing SDA
    exp_bus.push_back(3);
    exp_done.push_back('{nk, wrexp});

    d0 = done_cnt;
    issue(a, rw, msb, num);
    check("busy_after_cmd", bus.busy, 1);
    check("cmd_ready_busy", bus.cmd_ready, 0);
    repeat (3) @(negedge pclk);
    bus.cmd_valid = 1'b0;

    if (stall) begin
      for (int c = 0; c < 2000 && wr_seen == 0; c++) @(negedge pclk);
      hold = 1'b1;
      repeat (150) @(negedge pclk);
      hi = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge pclk);
        if (bus.scl_o) hi++;
      end
      check("stretch_scl_low", hi, 0);
      hold = 1'b0;
    end

    for (int c = 0; c < 40000 && done_cnt == d0; c++) @(negedge pclk);
    check("done_seen", (done_cnt != d0) ? 1 : 0, 1);
    @(negedge pclk);
    check("nack_held", bus.nack, nk);
    check("idle_ready", bus.cmd_ready, 1);
    check("idle_lines", {bus.scl_o, bus.sda_o}, 2'b11);
    check("bus_queue_left", exp_bus.size(), 0);
    check("rd_queue_left", exp_rd.size(), 0);
    check("done_queue_left", exp_done.size(), 0);
    exp_bus.delete(); exp_rd.delete(); exp_done.delete(); wq.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, ra, rn, rnk;
    logic rrw, rmsb, ranack;
    areset = 1'b1; hold = 1'b0; mon_en = 1'b1;
    cfg_rw = 1'b0; cfg_msb = 1'b1; cfg_anack = 1'b0; cfg_n = 0;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_read_write = 1'b0;
    bus.cmd_msb_first = 1'b1; bus.cmd_num_bytes = '0;
    for (int i = 0; i < 128; i++) begin wack[i] = 1'b0; rbytes[i] = '0; pat[i] = '0; end
    repeat (3) @(negedge pclk);
    check("rst_scl", bus.scl_o, 1);
    check("rst_sda", bus.sda_o, 1);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_nack", bus.nack, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_rd_data", bus.rd_data, 0);
    areset = 1'b0;
    repeat (2) @(negedge pclk);

    pat[0] = 8'hA5; pat[1] = 8'h3C;
    run_xfer(7'h50, 1'b0, 1'b1, 2, 1'b0, -1, 1'b0);
    pat[0] = 8'h01;
    run_xfer(7'h50, 1'b0, 1'b0, 1, 1'b0, -1, 1'b0);
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
    run_xfer(7'h1D, 1'b1, 1'b1, 3, 1'b0, -1, 1'b0);
    fill_pat();
    run_xfer(7'($urandom), 1'b0, 1'b1, 4, 1'b1, -1, 1'b0);
    fill_pat();
    run_xfer(7'($urandom), 1'b0, 1'b1, 3, 1'b0, -1, 1'b1);
    run_xfer(7'($urandom), 1'b0, 1'b1, 0, 1'b0, -1, 1'b0);
    fill_pat();
    run_xfer(7'($urandom), 1'b0, 1'b0, 3, 1'b0, 1, 1'b0);
    fill_pat();
    run_xfer(7'($urandom), 1'b1, 1'b0, 2, 1'b0, -1, 1'b0);
    fill_pat();
    run_xfer(7'($urandom), 1'b1, 1'b1, 200, 1'b0, -1, 1'b0);

    // Reset in the middle of read byte 0, bit 3 (SCL high).
    mon_en = 1'b0;
    fill_pat();
    cfg_rw = 1'b1; cfg_msb = 1'b1; cfg_anack = 1'b0; cfg_n = 2;
    for (int i = 0; i < 128; i++) begin wack[i] = 1'b0; rbytes[i] = pat[i]; end
    s0 = start_cnt;
    issue(7'h2A, 1'b1, 1'b1, 2);
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 3000 && !(start_cnt != s0 && rise_idx >= 13); c++) @(negedge pclk);
    check("reached_rd_bit3", rise_idx, 13);
    #1 areset = 1'b1;
    #1;
    check("arst_scl", bus.scl_o, 1);
    check("arst_sda", bus.sda_o, 1);
    check("arst_busy", bus.busy, 0);
    check("arst_cmd_ready", bus.cmd_ready, 1);
    check("arst_rd_valid", bus.rd_valid, 0);
    repeat (3) @(negedge pclk);
    areset = 1'b0;
    repeat (3) @(negedge pclk);
    mon_en = 1'b1;

    for (int k = 0; k < 10; k++) begin
      fill_pat();
      ra     = int'($urandom_range(0, 127));
      rrw    = 1'($urandom);
      rmsb   = 1'($urandom);
      rn     = int'($urandom_range(0, 4));
      ranack = ($urandom_range(0, 5) == 0);
      rnk    = -1;
      if (!rrw && rn > 0 && $urandom_range(0, 3) == 0) rnk = int'($urandom_range(0, rn - 1));
      run_xfer(7'(ra), rrw, rmsb, rn, ranack, rnk, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
